// File: rtl/rd_path_pkg.sv
// Shared definitions for the DDR frame read path: FSM state encoding and AXI/address constants.
package rd_path_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        AR    = 3'd2,
        RDAT  = 3'd3,
        DONE  = 3'd4
    } rd_state_t;

    localparam int         BEAT_ADDR_STEP = 8;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rd_burst_split.sv
// Splits a line into AXI INCR bursts: tracks remaining beats, next burst address and beats left in the
// current burst, and presents araddr/arlen for the burst about to be requested.
module rd_burst_split
    import rd_path_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  ar_fire,
    input  logic                  beat,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic                  remain_last,
    output logic                  burst_last
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST);

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  remain_reg;
    logic [8:0]            burst_left_reg;
    logic [LEN_WIDTH-1:0]  size;
    logic [ADDR_WIDTH-1:0] step;

    assign size = (remain_reg > MAX_LEN) ? MAX_LEN : remain_reg;
    assign step = ADDR_WIDTH'(size) * ADDR_WIDTH'(BEAT_ADDR_STEP);

    // arlen is forced to 0 when nothing remains so the idle/reset value of the port is 0
    assign arlen       = (size == '0) ? 8'd0 : 8'(size - LEN_WIDTH'(1));
    assign araddr      = addr_reg;
    assign remain_last = (remain_reg == LEN_WIDTH'(1));
    assign burst_last  = (burst_left_reg == 9'd1);

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_reg       <= '0;
            remain_reg     <= '0;
            burst_left_reg <= '0;
        end else if (load) begin
            addr_reg       <= load_addr;
            remain_reg     <= load_len;
            burst_left_reg <= '0;
        end else begin
            if (ar_fire) begin
                addr_reg       <= addr_reg + step;
                burst_left_reg <= 9'(size);
            end
            if (beat && (burst_left_reg != 9'd0)) begin
                remain_reg     <= remain_reg - LEN_WIDTH'(1);
                burst_left_reg <= burst_left_reg - 9'd1;
            end
        end
    end

endmodule

// File: rtl/rd_axi_burst_master.sv
// DDR read burst engine: one line request -> AXI4 INCR read bursts (one outstanding) -> beats to line buffer.
// Optional response checker enabled by defining RD_RESP_CHK_EN (drives sticky rd_err).
module rd_axi_burst_master
    import rd_path_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32,
    parameter int MAX_BURST  = 16,
    parameter int AXI_ID     = 0
) (
    input  logic                    ddr_clk,
    input  logic                    ddr_rst,
    input  logic                    ddr_rreq,
    input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
    input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
    output logic                    ddr_rrdy,
    output logic                    ddr_rdone,
    output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
    output logic                    ddr_rdata_en,
    output logic [3:0]              axi_arid,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    output logic                    rd_err
);

    rd_state_t             state_reg;
    logic                  rrdy_reg;
    logic                  rdone_reg;
    logic                  arvalid_reg;
    logic                  rready_reg;
    logic                  rdata_en_reg;
    logic [8*DQ_WIDTH-1:0] rdata_reg;
    logic                  beat;
    logic                  ar_fire;
    logic                  remain_last;
    logic                  burst_last;

    assign beat    = axi_rvalid && rready_reg;
    assign ar_fire = arvalid_reg && axi_arready;

    rd_burst_split #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_split (
        .clk         (ddr_clk),
        .srst        (ddr_rst),
        .load        (state_reg == LATCH),
        .load_addr   (ddr_raddr),
        .load_len    (ddr_rd_len),
        .ar_fire     (ar_fire),
        .beat        (beat),
        .araddr      (axi_araddr),
        .arlen       (axi_arlen),
        .remain_last (remain_last),
        .burst_last  (burst_last)
    );

    // Burst end is decided by the beat count, never by axi_rlast
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_reg   <= IDLE;
            rrdy_reg    <= 1'b0;
            rdone_reg   <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
        end else begin
            rrdy_reg  <= 1'b0;
            rdone_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // rdone_reg high means the previous line just finished; its request may still be up
                    if (ddr_rreq && !rdone_reg) begin
                        state_reg <= LATCH;
                        rrdy_reg  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (ddr_rd_len == '0) begin
                        state_reg <= DONE;
                    end else begin
                        state_reg   <= AR;
                        arvalid_reg <= 1'b1;
                    end
                end
                AR: begin
                    if (axi_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RDAT;
                    end
                end
                RDAT: begin
                    if (beat && burst_last) begin
                        rready_reg <= 1'b0;
                        if (remain_last) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg   <= AR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    rdone_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            rdata_reg    <= '0;
            rdata_en_reg <= 1'b0;
        end else begin
            rdata_en_reg <= beat;
            if (beat) begin
                rdata_reg <= axi_rdata;
            end
        end
    end

`ifdef RD_RESP_CHK_EN
    logic err_reg;

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            err_reg <= 1'b0;
        end else if (beat && ((axi_rresp != AXI_RESP_OKAY) || (axi_rlast != burst_last))) begin
            err_reg <= 1'b1;
        end
    end

    assign rd_err = err_reg;
`else
    logic unused_chk;
    assign unused_chk = ^{axi_rresp, axi_rlast};
    assign rd_err     = 1'b0;
`endif

    assign ddr_rrdy     = rrdy_reg;
    assign ddr_rdone    = rdone_reg;
    assign ddr_rdata    = rdata_reg;
    assign ddr_rdata_en = rdata_en_reg;
    assign axi_arid     = 4'(AXI_ID);
    assign axi_arvalid  = arvalid_reg;
    assign axi_rready   = rready_reg;

endmodule

// File: tb/tb_rd_axi_burst_master.sv
// Directed bench for rd_axi_burst_master: AXI slave model, beat scoreboard and hand-computed burst tables.
module tb_rd_axi_burst_master;

    localparam int AW = 27;
    localparam int LW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          ddr_rst;
    logic          ddr_rreq;
    logic [AW-1:0] ddr_raddr;
    logic [LW-1:0] ddr_rd_len;
    logic          ddr_rrdy;
    logic          ddr_rdone;
    logic [8*DW-1:0] ddr_rdata;
    logic          ddr_rdata_en;
    logic [3:0]    axi_arid;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [8*DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;
    logic          rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    // slave / monitor state
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_len_q[$];
    int  n_rrdy = 0, n_rdone = 0, n_ar = 0, n_beats = 0, n_hold = 0;
    int  seq = 0, exp_seq = 0, beats_left = 0, hold_cnt = 0, beat_in_line = 0;
    int  ar_hold = 0, bad_beat = -1, cur_len = 0;
    bit  rand_mode = 0, ar_fire_p = 0, r_fire_p = 0, prev_en = 0;
    logic [AW-1:0] h_addr;
    logic [7:0]    h_len;

    rd_axi_burst_master dut (
        .ddr_clk      (clk),
        .ddr_rst      (ddr_rst),
        .ddr_rreq     (ddr_rreq),
        .ddr_raddr    (ddr_raddr),
        .ddr_rd_len   (ddr_rd_len),
        .ddr_rrdy     (ddr_rrdy),
        .ddr_rdone    (ddr_rdone),
        .ddr_rdata    (ddr_rdata),
        .ddr_rdata_en (ddr_rdata_en),
        .axi_arid     (axi_arid),
        .axi_araddr   (axi_araddr),
        .axi_arlen    (axi_arlen),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rlast    (axi_rlast),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .rd_err       (rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*DW-1:0] pat(input int s);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(s);
        return {8{w}};
    endfunction

    // AXI slave + output monitor, evaluated mid-cycle
    initial begin : axi_slave
        logic [AW-1:0] p_addr;
        logic [7:0]    p_len;
        p_addr = '0;
        p_len  = '0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (ddr_rst) begin
                ar_fire_p = 0; r_fire_p = 0; beats_left = 0; hold_cnt = 0; prev_en = 0;
                axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
            end else begin
                if (ddr_rdata_en || r_fire_p)
                    check_val("rdata_en_latency", ddr_rdata_en, r_fire_p);
                if (ddr_rdata_en) begin
                    check_val("rdata", ddr_rdata, pat(exp_seq));
                    exp_seq++;
                    n_beats++;
                end
                if (ddr_rrdy) begin
                    n_rrdy++;
                    beat_in_line = 0;
                end
                if (ddr_rdone) begin
                    n_rdone++;
                    check_val("rdone_with_en", ddr_rdata_en, 0);
                    if (cur_len != 0) check_val("rdone_after_last_en", prev_en, 1);
                end
                prev_en = ddr_rdata_en;
                if (ar_fire_p) begin
                    n_ar++;
                    if (exp_addr_q.size() == 0) begin
                        check_val("ar_unexpected", exp_addr_q.size(), 1);
                    end else begin
                        check_val("araddr", p_addr, exp_addr_q.pop_front());
                        check_val("arlen", p_len, exp_len_q.pop_front());
                    end
                    beats_left = int'(p_len) + 1;
                    hold_cnt = 0;
                end
                if (r_fire_p) begin
                    seq++;
                    beats_left--;
                    beat_in_line++;
                end
                if (axi_arvalid) begin
                    if (hold_cnt < ar_hold) begin
                        if (hold_cnt == 0) begin
                            h_addr = axi_araddr;
                            h_len  = axi_arlen;
                        end else begin
                            check_val("ar_hold_addr", axi_araddr, h_addr);
                            check_val("ar_hold_len", axi_arlen, h_len);
                        end
                        hold_cnt++;
                        n_hold++;
                        axi_arready = 1'b0;
                    end else begin
                        axi_arready = 1'b1;
                    end
                end else begin
                    axi_arready = 1'b0;
                end
                if (beats_left > 0) begin
                    axi_rvalid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                    axi_rdata  = pat(seq);
                    axi_rlast  = (beats_left == 1);
                    axi_rresp  = (beat_in_line == bad_beat) ? 2'b10 : 2'b00;
                end else begin
                    axi_rvalid = 1'b0;
                    axi_rlast  = 1'b0;
                    axi_rresp  = 2'b00;
                end
                ar_fire_p = axi_arvalid && axi_arready;
                if (ar_fire_p) begin
                    p_addr = axi_araddr;
                    p_len  = axi_arlen;
                end
                r_fire_p = axi_rvalid && axi_rready;
            end
        end
    end

    task automatic check_zero(input string tag);
        check_val({tag, " rrdy"}, ddr_rrdy, 0);
        check_val({tag, " rdone"}, ddr_rdone, 0);
        check_val({tag, " rdata_en"}, ddr_rdata_en, 0);
        check_val({tag, " rdata"}, ddr_rdata, 0);
        check_val({tag, " arvalid"}, axi_arvalid, 0);
        check_val({tag, " araddr"}, axi_araddr, 0);
        check_val({tag, " arlen"}, axi_arlen, 0);
        check_val({tag, " rready"}, axi_rready, 0);
        check_val({tag, " rd_err"}, rd_err, 0);
        check_val({tag, " arid"}, axi_arid, 0);
    endtask

    task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l);
        exp_addr_q.push_back(a);
        exp_len_q.push_back(l);
    endtask

    // One full line; lazy keeps ddr_rreq up through the cycle after rdone
    task automatic run_line(input string tag, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input bit lazy, output int lat);
        int b0, r0, d0, a0, nexp, cyc, rr, rd;
        b0 = n_beats; r0 = n_rrdy; d0 = n_rdone; a0 = n_ar; nexp = exp_addr_q.size();
        cyc = 0; rr = -1; rd = -1;
        cur_len = int'(len);
        @(negedge clk); #2;
        ddr_raddr = addr; ddr_rd_len = len; ddr_rreq = 1'b1;
        while (rd < 0 && cyc < 3000) begin
            @(negedge clk); #2;
            cyc++;
            if (ddr_rrdy && rr < 0) rr = cyc;
            if (ddr_rdone) rd = cyc;
        end
        check_val({tag, " rdone_seen"}, (rd >= 0), 1);
        if (lazy) begin
            @(negedge clk); #2;
        end
        ddr_rreq = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check_val({tag, " rrdy_count"}, n_rrdy - r0, 1);
        check_val({tag, " rdone_count"}, n_rdone - d0, 1);
        check_val({tag, " beat_count"}, n_beats - b0, len);
        check_val({tag, " ar_count"}, n_ar - a0, nexp);
        check_val({tag, " ar_left"}, exp_addr_q.size(), 0);
        lat = rd - rr;
        $display("line %s addr=%0h len=%0d rrdy->rdone=%0d cycles", tag, addr, len, lat);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, b0, cyc, d0;
        ddr_rst = 1'b1; ddr_rreq = 1'b0; ddr_raddr = '0; ddr_rd_len = '0;
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        ddr_rst = 1'b0;
        repeat (2) @(negedge clk);

        // 60 beats at 0x1000 -> 16,16,16,12
        push_ar(27'h1000, 8'd15); push_ar(27'h1080, 8'd15);
        push_ar(27'h1100, 8'd15); push_ar(27'h1180, 8'd11);
        run_line("len60", 27'h1000, 16'd60, 1'b0, lat);

        // zero length, request held through the cycle after rdone
        run_line("len0", 27'h0ABC, 16'd0, 1'b1, lat);
        check_val("len0 rrdy_to_rdone", lat, 2);

        // AR stall of 20 cycles
        ar_hold = 20; n_hold = 0;
        push_ar(27'h2000, 8'd4);
        run_line("arhold", 27'h2000, 16'd5, 1'b0, lat);
        check_val("arhold cycles", n_hold, 20);
        ar_hold = 0;

        // random rvalid, 37 beats -> 16,16,5
        rand_mode = 1;
        push_ar(27'h3000, 8'd15); push_ar(27'h3080, 8'd15); push_ar(27'h3100, 8'd4);
        run_line("randv", 27'h3000, 16'd37, 1'b0, lat);
        rand_mode = 0;

        // reset in the middle of the first burst
        push_ar(27'h4000, 8'd15); push_ar(27'h4080, 8'd15); push_ar(27'h4100, 8'd7);
        cur_len = 40; b0 = n_beats; d0 = n_rdone; cyc = 0;
        @(negedge clk); #2;
        ddr_raddr = 27'h4000; ddr_rd_len = 16'd40; ddr_rreq = 1'b1;
        while ((n_beats - b0) < 3 && cyc < 200) begin
            @(negedge clk); #2;
            cyc++;
        end
        check_val("midrst beats_before", (n_beats - b0) >= 3, 1);
        ddr_rst = 1'b1; ddr_rreq = 1'b0;
        @(negedge clk); #2;
        check_zero("midrst");
        exp_addr_q.delete(); exp_len_q.delete();
        ddr_rst = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check_val("midrst no_rdone", n_rdone - d0, 0);
        push_ar(27'h5000, 8'd15); push_ar(27'h5080, 8'd3);
        run_line("postrst", 27'h5000, 16'd20, 1'b0, lat);

        // SLVERR on the fifth beat
        check_val("resp err_before", rd_err, 0);
        bad_beat = 4;
        push_ar(27'h6000, 8'd7);
        run_line("resp", 27'h6000, 16'd8, 1'b0, lat);
        bad_beat = -1;
`ifdef RD_RESP_CHK_EN
        check_val("resp rd_err_set", rd_err, 1);
        push_ar(27'h6100, 8'd2);
        run_line("sticky", 27'h6100, 16'd3, 1'b0, lat);
        check_val("resp rd_err_sticky", rd_err, 1);
        ddr_rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check_val("resp rd_err_cleared", rd_err, 0);
        ddr_rst = 1'b0;
`else
        check_val("resp rd_err_tied", rd_err, 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
